pulse_sync_mc: RTL

PULSE_SYNC_MC -- requirements
Module: pulse_sync_mc

---
 rtl/pulse_sync_pkg.sv | 12 +
 rtl/pulse_sync_ch.sv | 85 ++++++++
 rtl/pulse_sync_mc.sv | 43 ++++
 3 files changed

// File: rtl/pulse_sync_pkg.sv
// Shared constants for the multi-channel pulse synchroniser: fast-side FSM
// encoding and the lower bound on synchroniser depth.
package pulse_sync_pkg;

    typedef logic [0:0] fsm_state_t;

    localparam fsm_state_t ST_IDLE = 1'b0;
    localparam fsm_state_t ST_WAIT = 1'b1;

    localparam int SYNC_STAGES_MIN = 2;

endpackage

// File: rtl/pulse_sync_ch.sv
// One pulse channel: fast-side event counter with req/ack toggle handshake,
// slow-side req synchroniser and edge detector producing one pulse per toggle.
module pulse_sync_ch
    import pulse_sync_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 3
) (
    input  logic             clk_fast,
    input  logic             clk_slow,
    input  logic             rst_n,
    input  logic             data_in,
    input  logic             ovf_clr,
    output logic             dataout,
    output logic             ovf,
    output fsm_state_t       state,
    output logic [CNT_W-1:0] pend
);

    localparam logic [CNT_W-1:0] PEND_MAX = '1;

    logic                   req;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic [SYNC_STAGES-1:0] req_sync;
    logic                   hist;

    fsm_state_t       state_nxt;
    logic [CNT_W-1:0] pend_nxt;
    logic             launch;
    logic             acked;
    logic             drop;

    // A launch and an arriving event in the same cycle cancel out in pend.
    always_comb begin
        launch    = (state == ST_IDLE) && (pend != '0);
        acked     = (ack_sync[SYNC_STAGES-1] == req);
        drop      = data_in && !launch && (pend == PEND_MAX);
        state_nxt = state;
        pend_nxt  = pend;
        if (launch) begin
            state_nxt = ST_WAIT;
        end else if ((state == ST_WAIT) && acked) begin
            state_nxt = ST_IDLE;
        end
        if (data_in && !launch && !drop) begin
            pend_nxt = pend + 1'b1;
        end else if (!data_in && launch) begin
            pend_nxt = pend - 1'b1;
        end
    end

    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            pend     <= '0;
            req      <= 1'b0;
            ack_sync <= '0;
            ovf      <= 1'b0;
        end else begin
            state    <= state_nxt;
            pend     <= pend_nxt;
            req      <= req ^ launch;
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], req_sync[SYNC_STAGES-1]};
            if (drop) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

    // The last req stage doubles as the ack toggle sent back to clk_fast.
    always_ff @(posedge clk_slow or negedge rst_n) begin
        if (!rst_n) begin
            req_sync <= '0;
            hist     <= 1'b0;
        end else begin
            req_sync <= {req_sync[SYNC_STAGES-2:0], req};
            hist     <= req_sync[SYNC_STAGES-1];
        end
    end

    assign dataout = req_sync[SYNC_STAGES-1] ^ hist;

endmodule

// File: rtl/pulse_sync_mc.sv
// Multi-channel pulse synchroniser from clk_fast to clk_slow with per-channel
// pending-event counting, busy indication and sticky overflow flags.
module pulse_sync_mc
    import pulse_sync_pkg::*;
#(
    parameter int CH          = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 3
) (
    input  logic          clk_fast,
    input  logic          clk_slow,
    input  logic          rst_n,
    input  logic [CH-1:0] data_in,
    input  logic [CH-1:0] ovf_clr,
    output logic [CH-1:0] dataout,
    output logic [CH-1:0] busy,
    output logic [CH-1:0] ovf
);

    fsm_state_t       ch_state [CH];
    logic [CNT_W-1:0] ch_pend  [CH];

    for (genvar i = 0; i < CH; i++) begin : g_ch
        pulse_sync_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .CNT_W       (CNT_W)
        ) u_ch (
            .clk_fast (clk_fast),
            .clk_slow (clk_slow),
            .rst_n    (rst_n),
            .data_in  (data_in[i]),
            .ovf_clr  (ovf_clr[i]),
            .dataout  (dataout[i]),
            .ovf      (ovf[i]),
            .state    (ch_state[i]),
            .pend     (ch_pend[i])
        );

        // Built only from clk_fast flops, so it never sees CDC glitches.
        assign busy[i] = (ch_pend[i] != '0) || (ch_state[i] == ST_WAIT);
    end

endmodule
